// File: rtl/lsu_mem_resp.sv
// lsu_mem_resp: memory-side back end of the load/store unit.
//
// Passes dispatch MEM requests straight through to a 64-bit data bus. Accepted bus
// requests are tracked in order in a small FIFO. Read responses are matched to the
// FIFO head, and load data is lane-extracted and sign/zero-extended. Each response
// then leaves through a single registered writeback stage.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   req_*                    dispatch MEM request (valid/ready, type, address, store data, rd)
//   bus_req_*, bus_addr_o,
//   bus_we_o, bus_wmask_o,
//   bus_wdata_o              bus request channel (valid/ready)
//   bus_rsp_*                bus response channel (valid/ready, read data, error)
//   wb_*                     registered completion to writeback (valid/ready)
//   outst_cnt_o              entries currently held in the tracker FIFO
//   spurious_rsp_o           response seen while the tracker is empty
module lsu_mem_resp #(
    parameter int unsigned OUTST_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_load_i,
    input  logic        req_store_i,
    input  logic        req_lb_i,
    input  logic        req_lh_i,
    input  logic        req_lw_i,
    input  logic        req_lbu_i,
    input  logic        req_lhu_i,
    input  logic [31:0] req_addr_i,
    input  logic [7:0]  req_wmask_i,
    input  logic [63:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        bus_req_valid_o,
    input  logic        bus_req_ready_i,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [7:0]  bus_wmask_o,
    output logic [63:0] bus_wdata_o,
    input  logic        bus_rsp_valid_i,
    output logic        bus_rsp_ready_o,
    input  logic [63:0] bus_rsp_rdata_i,
    input  logic        bus_rsp_err_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic        wb_err_o,
    output logic        wb_store_o,
    output logic [3:0]  outst_cnt_o,
    output logic        spurious_rsp_o
);

    localparam int unsigned PtrW = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] off;
        logic       lb;
        logic       lh;
        logic       lw;
        logic       lbu;
        logic       lhu;
        logic       store;
    } entry_t;

    entry_t          mem_q [OUTST_DEPTH];
    entry_t          mem_d [OUTST_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]      cnt_q, cnt_d;

    logic        wb_valid_q, wb_valid_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_we_q, wb_we_d;
    logic        wb_err_q, wb_err_d;
    logic        wb_store_q, wb_store_d;

    logic   full, empty, push, pop;
    entry_t new_entry, head;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] lane_w;
    logic [31:0] load_data;

    assign full  = (cnt_q == 4'(OUTST_DEPTH));
    assign empty = (cnt_q == 4'd0);

    // Request path: combinational pass-through. Requests that are neither load nor
    // store are acknowledged but never reach the bus.
    assign bus_req_valid_o = req_valid_i & (req_load_i | req_store_i) & ~full;
    assign req_ready_o     = bus_req_ready_i & ~full;
    assign bus_addr_o      = {req_addr_i[31:3], 3'b000};
    assign bus_we_o        = req_store_i;
    assign bus_wmask_o     = req_store_i ? req_wmask_i : 8'h00;
    assign bus_wdata_o     = req_wdata_i;

    assign push = bus_req_valid_o & bus_req_ready_i;

    // A response is only taken when the output register is free or draining this cycle.
    assign bus_rsp_ready_o = ~empty & (~wb_valid_q | wb_ready_i);
    assign pop             = bus_rsp_valid_i & bus_rsp_ready_o;
    assign spurious_rsp_o  = bus_rsp_valid_i & empty & ~rst;

    assign new_entry = '{rd: req_rd_i, off: req_addr_i[2:0], lb: req_lb_i, lh: req_lh_i,
                         lw: req_lw_i, lbu: req_lbu_i, lhu: req_lhu_i, store: req_store_i};
    assign head      = mem_q[rd_ptr_q];

    // Lane extraction from the 64-bit beat using the head's byte offset.
    assign lane_b = bus_rsp_rdata_i[8*head.off +: 8];
    assign lane_h = bus_rsp_rdata_i[16*head.off[2:1] +: 16];
    assign lane_w = bus_rsp_rdata_i[32*head.off[2] +: 32];

    always_comb begin
        load_data = 32'h0;
        if (head.lb) begin
            load_data = {{24{lane_b[7]}}, lane_b};
        end else if (head.lbu) begin
            load_data = {24'h0, lane_b};
        end else if (head.lh) begin
            load_data = {{16{lane_h[15]}}, lane_h};
        end else if (head.lhu) begin
            load_data = {16'h0, lane_h};
        end else if (head.lw) begin
            load_data = lane_w;
        end
    end

    // Tracker FIFO next state. Full blocks push through bus_req_valid_o, so a
    // simultaneous pop never frees a slot for the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Output register: loads on a response handshake, otherwise holds until accepted.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        wb_we_d    = wb_we_q;
        wb_err_d   = wb_err_q;
        wb_store_d = wb_store_q;
        if (pop) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = head.rd;
            wb_err_d   = bus_rsp_err_i;
            wb_store_d = head.store;
            wb_we_d    = ~head.store & ~bus_rsp_err_i;
            wb_data_d  = (head.store | bus_rsp_err_i) ? 32'h0 : load_data;
        end else if (wb_ready_i) begin
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= 4'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'h0;
            wb_we_q    <= 1'b0;
            wb_err_q   <= 1'b0;
            wb_store_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            wb_we_q    <= wb_we_d;
            wb_err_q   <= wb_err_d;
            wb_store_q <= wb_store_d;
        end
    end

    // Payload storage needs no reset; validity is carried by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;
    assign wb_we_o     = wb_we_q;
    assign wb_err_o    = wb_err_q;
    assign wb_store_o  = wb_store_q;
    assign outst_cnt_o = cnt_q;

endmodule
